alu_result_collector: RTL
=========================

Name: alu_result_collector

Overview:
- Consumer end of the dual simple-ALU result interface.
- Captures the registered result bundles from ALU unit 0 and ALU unit 1 into one FIFO per unit. This is needed because the ALUs have no output backpressure: valid_o is a one-cycle pulse and is never held.
- Drains both FIFOs round-robin onto a single common-data-bus (CDB) writeback port that uses a valid/ready handshake.
- Gives the issue stage per-unit almost-full stall signals, and flags overflow and flush events.

Parameters:
- FIFO_DEPTH, 4, entries per unit FIFO; power of two, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  pipeline flush; discards all buffered and incoming results
- alu0_valid_i  in  1  ALU0 result valid (single-cycle pulse per result)
- alu0_result_i  in  32  ALU0 result data
- alu0_rob_id_i  in  6  ALU0 ROB entry ID
- alu0_phys_dest_i  in  7  ALU0 physical destination register
- alu0_exception_i  in  1  ALU0 exception flag
- alu1_valid_i, alu1_result_i, alu1_rob_id_i, alu1_phys_dest_i, alu1_exception_i  in  1/32/6/7/1  same fields for ALU1
- alu0_almost_full_o  out  1  issue stall for ALU0
- alu1_almost_full_o  out  1  issue stall for ALU1
- cdb_valid_o  out  1  CDB bundle valid
- cdb_ready_i  in  1  CDB consumer accepts the bundle
- cdb_result_o  out  32  CDB result data
- cdb_rob_id_o  out  6  CDB ROB entry ID
- cdb_phys_dest_o  out  7  CDB physical destination register
- cdb_exception_o  out  1  CDB exception flag
- cdb_src_o  out  1  unit ID that produced the bundle (0 or 1)
- overflow_o  out  1  sticky error: a push arrived while that FIFO was full

Behaviour:
- Reset (rst high at a clk edge):
  - both FIFOs emptied; all pointers and counts set to 0.
  - rr_ptr=0, lock=0, overflow_o=0.
  - all CDB outputs read 0 while empty: cdb_valid_o=0, data=0, cdb_src_o=0.
  - almost_full outputs=0.
  - A reset in the middle of a stalled handshake drops the held bundle. Nothing is replayed.
- FIFO entry: 46 bits = {exception, phys_dest, rob_id, result}.
  - Push on aluN_valid_i at a clk edge.
  - count per FIFO ranges 0..FIFO_DEPTH.
- Latency: a result pushed at edge N into an empty system appears on cdb_valid_o after edge N (zero added combinational path from input to output).
  - CDB outputs are driven combinationally from FIFO storage and registered selection state only.
- Arbitration:
  - One FIFO nonempty: select that FIFO.
  - Both FIFOs nonempty: select the FIFO indicated by rr_ptr.
  - After each handshake (cdb_valid_o & cdb_ready_i), rr_ptr is set to the FIFO that did not win.
  - Neither FIFO nonempty: cdb_valid_o=0.
- Stability: while cdb_valid_o=1 and cdb_ready_i=0, lock=1. The selection and all cdb_* fields hold constant until the handshake, even if the other FIFO becomes nonempty or has priority.
- Pop: happens on handshake only, from the selected FIFO.
- Simultaneous push and pop on the same FIFO: count unchanged.
  - This is allowed when the FIFO is full. The push is accepted and no overflow occurs.
- Full: push while count==FIFO_DEPTH with no pop that cycle:
  - the entry is dropped;
  - overflow_o is set and stays 1 until rst;
  - FIFO contents are unchanged.
- Almost-full: aluN_almost_full_o = (count >= FIFO_DEPTH-1), registered from next-state count.
  - One slot stays reserved for the op already inside the 1-cycle ALU when issue sees the stall.
- Flush:
  - On an edge with flush_i=1, both FIFOs are cleared; lock=0 and rr_ptr=0.
  - A push and a pop in that same cycle are discarded. Flush wins over push.
  - In the flush cycle the outputs still show the pre-flush head.
  - Whether a pending handshake completed in that cycle does not matter to the collector.
- Pointer wrap: read and write pointers are PTR_W bits and wrap modulo FIFO_DEPTH. Full and empty are distinguished by count.
- Exception bit passes through unmodified. The collector never creates exceptions.

Test Plan:
- Single result: after reset, hold cdb_ready_i=1; pulse alu0 {result=32'h12345678, rob_id=5, phys_dest=33}. Required: cdb_valid_o=1 the next cycle with those fields and cdb_src_o=0, then 0 the cycle after.
- Simultaneous arrival: alu0 (rob 1) and alu1 (rob 2) in the same cycle, ready=1. Required: CDB order rob 1 then rob 2, since rr_ptr=0 after reset; rr_ptr then points to unit 0.
- Backpressure hold: ready=0, push alu1 rob 7, then push alu0 rob 8 while stalled. Required: cdb shows rob 7 and src=1 unchanged for 5 cycles. On ready=1, rob 7 then rob 8.
- Fill and overflow: ready=0, push 4 alu0 results. Required: almost_full rises after the 3rd push. A 5th push leaves count=4 and sets overflow_o=1. Draining yields the first four in order.
- Full push+pop: FIFO0 full, ready=1, push same cycle. Required: no overflow and count stays 4.
- Flush: 3 entries buffered, then flush_i with a coincident alu1 push. Required: cdb_valid_o=0 the next cycle, almost_full=0, and no entry emerges.

Source files
------------

// File: rtl/alu_result_collector.sv
`default_nettype none
//============================================================================
// Module      : alu_result_collector
// Description : Consumer end of the dual simple-ALU result interface.
//               Each ALU's registered result pulse is captured into a
//               per-unit FIFO, because the ALUs cannot be backpressured.
//               The two FIFOs are drained round-robin onto a single CDB
//               writeback port with a valid/ready handshake.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   flush_i               discard all buffered and incoming results
//   alu0_*_i / alu1_*_i   per-unit result bundle (valid is a 1-cycle pulse)
//   alu0/1_almost_full_o  registered issue stall per unit
//   cdb_valid_o/ready_i   CDB handshake
//   cdb_result_o, cdb_rob_id_o, cdb_phys_dest_o, cdb_exception_o
//                         CDB bundle fields (all zero while not valid)
//   cdb_src_o             unit that produced the presented bundle
//   overflow_o            sticky: a result was dropped on a full FIFO
//
// Revision    : 1.0 - initial release
//============================================================================
module alu_result_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,

    input  logic        alu0_valid_i,
    input  logic [31:0] alu0_result_i,
    input  logic [5:0]  alu0_rob_id_i,
    input  logic [6:0]  alu0_phys_dest_i,
    input  logic        alu0_exception_i,

    input  logic        alu1_valid_i,
    input  logic [31:0] alu1_result_i,
    input  logic [5:0]  alu1_rob_id_i,
    input  logic [6:0]  alu1_phys_dest_i,
    input  logic        alu1_exception_i,

    output logic        alu0_almost_full_o,
    output logic        alu1_almost_full_o,

    output logic        cdb_valid_o,
    input  logic        cdb_ready_i,
    output logic [31:0] cdb_result_o,
    output logic [5:0]  cdb_rob_id_o,
    output logic [6:0]  cdb_phys_dest_o,
    output logic        cdb_exception_o,
    output logic        cdb_src_o,

    output logic        overflow_o
);

    // Entry layout: {exception, phys_dest, rob_id, result}
    localparam int             c_ENTRY_W = 46;
    localparam logic [PTR_W:0] c_DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    // One slot is kept in reserve for the op already inside the ALU
    // when issue observes the stall.
    localparam logic [PTR_W:0] c_AF_LVL  = (PTR_W+1)'(FIFO_DEPTH - 1);

    //------------------------------------------------------------------
    // State
    //------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] mem_q    [2][FIFO_DEPTH];
    logic [c_ENTRY_W-1:0] mem_d    [2][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [2];
    logic [PTR_W-1:0]     wr_ptr_d [2];
    logic [PTR_W-1:0]     rd_ptr_q [2];
    logic [PTR_W-1:0]     rd_ptr_d [2];
    logic [PTR_W:0]       count_q  [2];
    logic [PTR_W:0]       count_d  [2];
    logic [1:0]           af_q, af_d;
    logic                 overflow_q, overflow_d;
    logic                 lock_q, lock_d;
    logic                 sel_q, sel_d;
    logic                 rr_ptr_q, rr_ptr_d;

    //------------------------------------------------------------------
    // Input bundling
    //------------------------------------------------------------------
    logic [1:0]           w_push;
    logic [c_ENTRY_W-1:0] w_push_data [2];

    always_comb begin
        w_push[0]      = alu0_valid_i;
        w_push[1]      = alu1_valid_i;
        w_push_data[0] = {alu0_exception_i, alu0_phys_dest_i, alu0_rob_id_i, alu0_result_i};
        w_push_data[1] = {alu1_exception_i, alu1_phys_dest_i, alu1_rob_id_i, alu1_result_i};
    end

    //------------------------------------------------------------------
    // Selection and CDB outputs (registered state only, no input path)
    //------------------------------------------------------------------
    logic [1:0]           w_nonempty;
    logic                 w_sel;
    logic                 w_valid;
    logic                 w_hs;
    logic [c_ENTRY_W-1:0] w_head;

    always_comb begin
        w_nonempty[0] = (count_q[0] != '0);
        w_nonempty[1] = (count_q[1] != '0);

        // While a bundle is stalled the selection is frozen; the locked
        // FIFO cannot empty because pops only follow a handshake.
        if (lock_q) begin
            w_sel = sel_q;
        end else if (w_nonempty[0] && w_nonempty[1]) begin
            w_sel = rr_ptr_q;
        end else if (w_nonempty[1]) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end

        w_valid = w_nonempty[w_sel];
        w_hs    = w_valid & cdb_ready_i;
        w_head  = mem_q[w_sel][rd_ptr_q[w_sel]];
    end

    always_comb begin
        cdb_valid_o     = w_valid;
        cdb_result_o    = w_valid ? w_head[31:0]  : 32'd0;
        cdb_rob_id_o    = w_valid ? w_head[37:32] : 6'd0;
        cdb_phys_dest_o = w_valid ? w_head[44:38] : 7'd0;
        cdb_exception_o = w_valid & w_head[45];
        cdb_src_o       = w_valid & w_sel;
    end

    //------------------------------------------------------------------
    // FIFO next-state
    //------------------------------------------------------------------
    logic [1:0] w_pop;
    logic [1:0] w_full;
    logic [1:0] w_accept;

    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q;
        for (int u = 0; u < 2; u++) begin
            w_pop[u]    = w_hs & (w_sel == u[0]);
            w_full[u]   = (count_q[u] == c_DEPTH);
            // A push into a full FIFO still fits when the same FIFO pops
            // in this cycle: the freed slot is the one being written.
            w_accept[u] = w_push[u] & (~w_full[u] | w_pop[u]);

            wr_ptr_d[u] = wr_ptr_q[u];
            rd_ptr_d[u] = rd_ptr_q[u];
            count_d[u]  = count_q[u];

            if (flush_i) begin
                wr_ptr_d[u] = '0;
                rd_ptr_d[u] = '0;
                count_d[u]  = '0;
            end else begin
                if (w_accept[u]) begin
                    mem_d[u][wr_ptr_q[u]] = w_push_data[u];
                    wr_ptr_d[u]           = wr_ptr_q[u] + PTR_W'(1);
                end
                if (w_pop[u]) begin
                    rd_ptr_d[u] = rd_ptr_q[u] + PTR_W'(1);
                end
                if (w_push[u] && !w_accept[u]) begin
                    overflow_d = 1'b1;
                end
                count_d[u] = count_q[u]
                           + {{PTR_W{1'b0}}, w_accept[u]}
                           - {{PTR_W{1'b0}}, w_pop[u]};
            end

            af_d[u] = (count_d[u] >= c_AF_LVL);
        end
    end

    //------------------------------------------------------------------
    // Arbitration next-state
    //------------------------------------------------------------------
    always_comb begin
        sel_d = w_sel;
        if (flush_i) begin
            lock_d   = 1'b0;
            rr_ptr_d = 1'b0;
        end else begin
            lock_d   = w_valid & ~cdb_ready_i;
            // The loser of a handshake gets priority next time.
            rr_ptr_d = w_hs ? ~w_sel : rr_ptr_q;
        end
    end

    //------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[u][i] <= '0;
                end
                wr_ptr_q[u] <= '0;
                rd_ptr_q[u] <= '0;
                count_q[u]  <= '0;
            end
            af_q       <= '0;
            overflow_q <= 1'b0;
            lock_q     <= 1'b0;
            sel_q      <= 1'b0;
            rr_ptr_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            af_q       <= af_d;
            overflow_q <= overflow_d;
            lock_q     <= lock_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        alu0_almost_full_o = af_q[0];
        alu1_almost_full_o = af_q[1];
        overflow_o         = overflow_q;
    end

endmodule : alu_result_collector
`default_nettype wire
